// File: rtl/window_kxk_stream.sv
// Streaming KxK neighbourhood generator: K-1 line buffers feed a KxK shift window, one window per pixel.
// Define WINDOW_REPLICATE_EN to clamp out-of-image taps to the nearest edge pixel instead of zero.
module window_kxk_stream #(
  parameter int IMG_W = 480,
  parameter int IMG_H = 272,
  parameter int K     = 3,
  parameter int PIX_W = 24,
  parameter int ROW_W = 9,
  parameter int COL_W = 9
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIX_W-1:0]       s_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [K*K*PIX_W-1:0]   o_data,
  output logic                   frame_done
);

  localparam int R  = (K - 1) / 2;
  localparam int IW = $clog2(K);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] R_COL    = COL_W'(R);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] R_ROW    = ROW_W'(R);
  localparam logic [ROW_W-1:0] END_ROW  = ROW_W'(IMG_H);

  if (!(K == 3 || K == 5) || IMG_W < K || IMG_H < K) begin : g_bad_cfg
    $error("window_kxk_stream: unsupported K or image smaller than window");
  end

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [PIX_W-1:0] line_buf [K-1][IMG_W];
  logic [PIX_W-1:0] win      [K][K];
  logic [PIX_W-1:0] col_in   [K];
  logic [ROW_W-1:0] pix_row, cnt_row, cen_row;
  logic [COL_W-1:0] pix_col, cnt_col, cen_col;
  logic             free, adv, emit, in_hs, last_pix, last_hs;
  int               tr, tc;

  assign free     = !o_valid || o_ready;
  assign in_hs    = s_valid && s_ready;
  assign last_pix = (pix_row == LAST_ROW) && (pix_col == LAST_COL);
  assign last_hs  = o_valid && o_ready && (cen_row == LAST_ROW) && (cen_col == LAST_COL);
  // A window exists once the pixel R rows and R columns past its centre has arrived.
  assign emit     = adv && ((pix_row > R_ROW) || ((pix_row == R_ROW) && (pix_col >= R_COL)));

  always_ff @(posedge iClk) begin
    if (iRst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:   if (in_hs && last_pix) state_nxt = FLUSH;
      FLUSH: if (last_hs)           state_nxt = RUN;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    adv     = 1'b0;
    case (state)
      RUN: begin
        s_ready = free;
        adv     = free && s_valid;
      end
      FLUSH: adv = free && (cnt_row != END_ROW);
    endcase
  end

  always_comb begin
    for (int i = 0; i < K - 1; i++) col_in[i] = line_buf[K-2-i][pix_col];
    col_in[K-1] = (state == RUN) ? s_data : '0;
  end

  always_ff @(posedge iClk) begin
    if (adv) begin
      line_buf[0][pix_col] <= col_in[K-1];
      for (int k = 1; k < K - 1; k++) line_buf[k][pix_col] <= line_buf[k-1][pix_col];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pix_row    <= '0;
      pix_col    <= '0;
      cnt_row    <= '0;
      cnt_col    <= '0;
      cen_row    <= '0;
      cen_col    <= '0;
      o_valid    <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
    end else begin
      frame_done <= last_hs;
      if (last_hs) begin
        pix_row <= '0;
        pix_col <= '0;
        cnt_row <= '0;
        cnt_col <= '0;
        o_valid <= 1'b0;
      end else if (adv) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
          win[i][K-1] <= col_in[i];
        end
        if (pix_col == LAST_COL) begin
          pix_col <= '0;
          pix_row <= pix_row + 1'b1;
        end else begin
          pix_col <= pix_col + 1'b1;
        end
        o_valid <= emit;
        if (emit) begin
          cen_row <= cnt_row;
          cen_col <= cnt_col;
          if (cnt_col == LAST_COL) begin
            cnt_col <= '0;
            cnt_row <= cnt_row + 1'b1;
          end else begin
            cnt_col <= cnt_col + 1'b1;
          end
        end
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  // Register columns that wrapped from the neighbouring line only ever sit at out-of-image taps.
  always_comb begin
    o_data = '0;
    tr     = 0;
    tc     = 0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        tr = int'(cen_row) + i - R;
        tc = int'(cen_col) + j - R;
`ifdef WINDOW_REPLICATE_EN
        if (tr < 0) tr = 0;
        else if (tr > IMG_H - 1) tr = IMG_H - 1;
        if (tc < 0) tc = 0;
        else if (tc > IMG_W - 1) tc = IMG_W - 1;
        o_data[(i*K+j)*PIX_W +: PIX_W] =
          win[IW'(tr - int'(cen_row) + R)][IW'(tc - int'(cen_col) + R)];
`else
        if (tr >= 0 && tr < IMG_H && tc >= 0 && tc < IMG_W)
          o_data[(i*K+j)*PIX_W +: PIX_W] = win[IW'(i)][IW'(j)];
`endif
      end
    end
  end

endmodule

// File: tb/tb_window_kxk_stream.sv
// Bench for window_kxk_stream: a K=3 (4x3) and a K=5 (6x5) instance checked every cycle against
// a coordinate-level window model built from the pixels actually accepted.
module tb_window_kxk_stream;
  localparam int PW = 16;
  localparam int WW = 25 * PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s_valid3, s_ready3, o_valid3, o_ready3, frame_done3;
  logic [PW-1:0]   s_data3;
  logic [9*PW-1:0] o_data3;
  logic s_valid5, s_ready5, o_valid5, o_ready5, frame_done5;
  logic [PW-1:0]    s_data5;
  logic [25*PW-1:0] o_data5;

  window_kxk_stream #(.IMG_W(4), .IMG_H(3), .K(3), .PIX_W(PW), .ROW_W(4), .COL_W(2)) dut3 (
    .iClk(clk), .iRst(rst), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
    .o_valid(o_valid3), .o_ready(o_ready3), .o_data(o_data3), .frame_done(frame_done3));

  window_kxk_stream #(.IMG_W(6), .IMG_H(5), .K(5), .PIX_W(PW), .ROW_W(4), .COL_W(3)) dut5 (
    .iClk(clk), .iRst(rst), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .o_valid(o_valid5), .o_ready(o_ready5), .o_data(o_data5), .frame_done(frame_done5));

  int checks = 0;
  int errors = 0;
  int pin[2], wcnt[2], nfd[2], totw[2], lat[2];
  bit stalled[2], fd_exp[2];
  logic [WW-1:0] held[2];
  int pbuf [2][30];
  logic [WW-1:0] cap [2][30];

  function automatic int kOf(input int d); return (d == 0) ? 3 : 5; endfunction
  function automatic int wOf(input int d); return (d == 0) ? 4 : 6; endfunction
  function automatic int hOf(input int d); return (d == 0) ? 3 : 5; endfunction

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window centred on raster index n, built from the recorded frame pixels.
  function automatic logic [WW-1:0] expWin(input int d, input int n);
    int k, w, h, r, cr, cc, tr, tc, v;
    logic [WW-1:0] res;
    k = kOf(d); w = wOf(d); h = hOf(d); r = (k - 1) / 2;
    cr = n / w; cc = n % w;
    res = '0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        tr = cr + i - r;
        tc = cc + j - r;
`ifdef WINDOW_REPLICATE_EN
        tr = (tr < 0) ? 0 : ((tr > h - 1) ? h - 1 : tr);
        tc = (tc < 0) ? 0 : ((tc > w - 1) ? w - 1 : tc);
        v = pbuf[d][tr*w+tc];
`else
        v = 0;
        if (tr >= 0 && tr < h && tc >= 0 && tc < w) v = pbuf[d][tr*w+tc];
`endif
        res[(i*k+j)*PW +: PW] = PW'(v);
      end
    end
    return res;
  endfunction

  task automatic monitorDut(input int d, input logic sv, input logic sr, input logic [PW-1:0] sd,
                            input logic ov, input logic ordy, input logic [WW-1:0] od, input logic fd);
    int k, w, h, off, wh;
    k = kOf(d); w = wOf(d); h = hOf(d);
    off = ((k - 1) / 2) * w + (k - 1) / 2;
    wh = w * h;
    if (rst) begin
      pin[d] = 0; wcnt[d] = 0; stalled[d] = 0; fd_exp[d] = 0;
      return;
    end
    checkOutput($sformatf("frame_done_d%0d", d), WW'(fd), WW'(fd_exp[d]));
    if (fd) begin
      nfd[d]++;
      checkOutput($sformatf("s_ready_at_frame_done_d%0d", d), WW'(sr), WW'(1));
    end
    fd_exp[d] = 0;
    if (stalled[d]) begin
      checkOutput($sformatf("stall_valid_d%0d", d), WW'(ov), WW'(1));
      checkOutput($sformatf("stall_data_d%0d", d), od, held[d]);
    end
    if (ov && !ordy) checkOutput($sformatf("s_ready_stall_d%0d", d), WW'(sr), WW'(0));
    if (ov && !stalled[d]) begin
      if (wcnt[d] == 0) lat[d] = pin[d];
      if (wcnt[d] + off < wh)
        checkOutput($sformatf("latency_d%0d_w%0d", d, wcnt[d]), WW'(pin[d]), WW'(wcnt[d] + off + 1));
      checkOutput($sformatf("window_d%0d_w%0d", d, wcnt[d]), od, expWin(d, wcnt[d]));
    end
    if (sv && sr) begin
      if (pin[d] >= wh) checkOutput($sformatf("input_overrun_d%0d", d), WW'(pin[d]), WW'(wh - 1));
      else begin
        pbuf[d][pin[d]] = int'(sd);
        pin[d]++;
      end
    end
    if (ov && ordy) begin
      cap[d][wcnt[d]] = od;
      wcnt[d]++;
      totw[d]++;
      if (wcnt[d] == wh) begin
        checkOutput($sformatf("pixels_in_frame_d%0d", d), WW'(pin[d]), WW'(wh));
        wcnt[d] = 0;
        pin[d] = 0;
        fd_exp[d] = 1;
      end
    end
    stalled[d] = ov && !ordy;
    held[d] = od;
  endtask

  always @(negedge clk) begin
    monitorDut(0, s_valid3, s_ready3, s_data3, o_valid3, o_ready3, WW'(o_data3), frame_done3);
    monitorDut(1, s_valid5, s_ready5, s_data5, o_valid5, o_ready5, o_data5, frame_done5);
  end

  // vmode 0: s_valid held high, 1: random. rmode 0: o_ready high, 1: pattern 1,0,0,1, 2: random.
  task automatic applyStimulus(input int d, input int npix, input bit seq, input int vmode,
                               input int rmode, input int budget);
    int ptr, cyc, fd0, wh;
    bit hs, v, r;
    logic [PW-1:0] dat;
    ptr = 0; cyc = 0; fd0 = nfd[d]; wh = wOf(d) * hOf(d);
    dat = seq ? PW'(1) : PW'($urandom);
    while ((ptr < npix || nfd[d] < fd0 + npix / wh) && cyc < budget) begin
      v = (ptr < npix) && (vmode == 0 || $urandom_range(0, 1) == 1);
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      if (d == 0) begin s_valid3 = v; s_data3 = dat; o_ready3 = r; end
      else        begin s_valid5 = v; s_data5 = dat; o_ready5 = r; end
      @(negedge clk);
      hs = v && ((d == 0) ? s_ready3 : s_ready5);
      @(posedge clk);
      #1;
      if (hs) begin
        ptr++;
        dat = seq ? PW'(ptr % wh + 1) : PW'($urandom);
      end
      cyc++;
    end
    if (d == 0) begin s_valid3 = 1'b0; o_ready3 = 1'b1; end
    else        begin s_valid5 = 1'b0; o_ready5 = 1'b1; end
    if (cyc >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_d%0d: used %0d cycles, limit %0d", d, cyc, budget);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    s_valid3 = 1'b0; o_ready3 = 1'b1;
    s_valid5 = 1'b0; o_ready5 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_o_valid3", WW'(o_valid3), WW'(0));
    checkOutput("reset_s_ready3", WW'(s_ready3), WW'(1));
    checkOutput("reset_frame_done3", WW'(frame_done3), WW'(0));
    checkOutput("reset_o_data3", WW'(o_data3), '0);
    checkOutput("reset_o_valid5", WW'(o_valid5), WW'(0));
    checkOutput("reset_s_ready5", WW'(s_ready5), WW'(1));
    checkOutput("reset_o_data5", o_data5, '0);
  endtask

  function automatic logic [WW-1:0] pack9(input int e [9]);
    logic [WW-1:0] res;
    res = '0;
    for (int i = 0; i < 9; i++) res[i*PW +: PW] = PW'(e[i]);
    return res;
  endfunction

  task automatic pinFrame3(input int t0);
    int lv [9];
`ifdef WINDOW_REPLICATE_EN
    lv = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
`else
    lv = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
`endif
    checkOutput("lit_k3_win00", cap[0][0], pack9(lv));
    lv = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    checkOutput("lit_k3_win11", cap[0][5], pack9(lv));
`ifdef WINDOW_REPLICATE_EN
    lv = '{7, 8, 8, 11, 12, 12, 11, 12, 12};
`else
    lv = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
`endif
    checkOutput("lit_k3_win23", cap[0][11], pack9(lv));
    checkOutput("lit_k3_first_latency", WW'(lat[0]), WW'(6));
    checkOutput("k3_window_count", WW'(totw[0] - t0), WW'(12));
  endtask

  initial begin
    int t0, f0, f1;
    logic [WW-1:0] e5;
    doReset();

    t0 = totw[0];
    fork
      applyStimulus(0, 12, 1'b1, 0, 0, 300);
      applyStimulus(1, 30, 1'b1, 0, 0, 400);
    join
    pinFrame3(t0);
    checkOutput("k3_frame_done_count", WW'(nfd[0]), WW'(1));
    e5 = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) e5[(r*5+c)*PW +: PW] = PW'(r * 6 + c + 1);
    checkOutput("lit_k5_win22", cap[1][14], e5);
    checkOutput("lit_k5_first_latency", WW'(lat[1]), WW'(15));
    checkOutput("k5_window_count", WW'(totw[1]), WW'(30));

    t0 = totw[0];
    applyStimulus(0, 12, 1'b1, 1, 1, 1000);
    pinFrame3(t0);

    f0 = nfd[0]; f1 = nfd[1];
    fork
      applyStimulus(0, 24, 1'b0, 1, 2, 3000);
      applyStimulus(1, 60, 1'b0, 1, 2, 6000);
    join
    checkOutput("random_frames_k3", WW'(nfd[0] - f0), WW'(2));
    checkOutput("random_frames_k5", WW'(nfd[1] - f1), WW'(2));

    applyStimulus(0, 7, 1'b1, 0, 0, 100);
    doReset();
    t0 = totw[0];
    applyStimulus(0, 12, 1'b1, 0, 0, 300);
    pinFrame3(t0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_kxk_stream.md
WINDOW_KXK_STREAM -- requirements
Module: window_kxk_stream

Interface
REQ-001 SHALL have parameters: IMG_W 480, image width in pixels; IMG_H 272, image height in lines; K 3, window size (3 or 5 only); PIX_W 24, pixel width; ROW_W 9, row counter width; COL_W 9, column counter width.
REQ-002 SHALL have ports: iClk  in  1  sole clock, rising edge.
REQ-003 iRst  in  1  synchronous, active-high reset.
REQ-004 s_valid  in  1  input pixel valid.
REQ-005 s_ready  out  1  block accepts input pixel.
REQ-006 s_data  in  PIX_W  input pixel, raster order.
REQ-007 o_valid  out  1  window valid.
REQ-008 o_ready  in  1  consumer accepts window.
REQ-009 o_data  out  K*K*PIX_W  window; element (r,c) at bits [(r*K+c)*PIX_W +: PIX_W]; (0,0) top-left at LSB.
REQ-010 frame_done  out  1  one-cycle pulse.

Function
REQ-011 SHALL hold K-1 line buffers of IMG_W x PIX_W plus a KxK shift-register window; R = (K-1)/2.
REQ-012 Input handshake completes when s_valid && s_ready; output handshake completes when o_valid && o_ready.
REQ-013 SHALL emit exactly IMG_W*IMG_H windows per frame, centred on (0,0)..(IMG_H-1,IMG_W-1) in raster order.
REQ-014 Window centred at linear index n SHALL become valid the cycle after the handshake of input pixel n + R*IMG_W + R; indices with no such input pixel are emitted during FLUSH.
REQ-015 Taps outside the image SHALL be padded per REQ-027; in-image taps equal the pixels at those coordinates.
REQ-016 States: RUN (accept input) and FLUSH (no input). RUN -> FLUSH after handshake of pixel IMG_W*IMG_H-1; FLUSH -> RUN after output handshake of the last window.
REQ-017 In RUN, s_ready = !o_valid || o_ready; in FLUSH, s_ready = 0.
REQ-018 In FLUSH, SHALL present one new window per cycle in which the output register is empty or handshaking; o_valid is never de-asserted without a handshake.
REQ-019 o_data SHALL be stable while o_valid && !o_ready.
REQ-020 frame_done SHALL pulse one cycle after the last window's output handshake; the next frame's first pixel is accepted in that same cycle.
REQ-021 Column and row counters SHALL wrap at IMG_W-1 and IMG_H-1 respectively with no lost or duplicated pixel.
REQ-022 Sustained throughput SHALL be one pixel in and one window out per cycle when s_valid and o_ready are held high.
REQ-023 IMG_W >= K and IMG_H >= K are required; other K values are illegal.

Reset
REQ-024 On iRst, state = RUN, all counters = 0, o_valid = 0, frame_done = 0, s_ready = 1 the following cycle, window registers = 0.
REQ-025 iRst asserted mid-frame SHALL abandon the frame; no further windows of that frame are emitted; the next accepted pixel is (0,0).
REQ-026 Line-buffer contents are not reset; no output may depend on stale line-buffer data.

Configuration
REQ-027 Macro WINDOW_REPLICATE_EN: defined -> out-of-image taps take the nearest in-image pixel (clamp row and column); undefined -> out-of-image taps are 0.

Verification
REQ-028 K=3, IMG_W=4, IMG_H=3, pixels 1..12, o_ready=1 -> first window o_valid one cycle after pixel 6 handshake, elements (0..8) = 0,0,0,0,1,2,0,5,6; 12 windows total; frame_done once.
REQ-029 Same frame, centre (1,1) -> window = 1,2,3,5,6,7,9,10,11; last window (2,3) = 7,8,0,11,12,0,0,0,0.
REQ-030 Same frame, WINDOW_REPLICATE_EN defined -> window (0,0) = 1,1,2,1,1,2,5,5,6; window (2,3) = 7,8,8,11,12,12,11,12,12.
REQ-031 o_ready toggled with pattern 1,0,0,1 and s_valid random -> o_data unchanged while stalled, s_ready low while o_valid && !o_ready, window sequence identical to REQ-028.
REQ-032 K=5, IMG_W=6, IMG_H=5, pixels 1..30 -> first window after pixel 15, window (2,2) = pixels 1..5,7..11,13..17,19..23,25..29 in raster order; 30 windows.
REQ-033 iRst pulsed after 7 input pixels, then full frame -> no window emitted after reset until pixel 6 of new frame; output matches REQ-028 exactly.
